// File: rtl/counter_pkg.sv
// Shared encodings for the counter controller slice.
// Command ops, FSM states and the packed step pair.
package counter_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] step2;
    logic [3:0] step1;
  } steps_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake bundle for counter_ctrl.
// Master offers ops; slave answers with cmd_ready.
interface counter_ctrl_if;
  import counter_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_e        cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled.
// wrap flags the edge on which DIV-1 rolls to 0.
module tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = en & (cnt == LAST);

  // Count while enabled, hold otherwise; clear wins.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Two-channel stepped counter driven by a prescaler.
// IDLE/RUN FSM, step regs and a one-deep LOAD buffer.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int DIV       = 1000000,
  parameter int STEP1_RST = 1,
  parameter int STEP2_RST = 4
) (
  input  logic           clk1,
  input  logic           rst_n,
  counter_ctrl_if.slave  cmd,
  output logic [7:0]     out_1,
  output logic [7:0]     out_2,
  output logic           running,
  output logic           tick
);

  localparam steps_t STEPS_RST = '{
    step2: 4'(STEP2_RST),
    step1: 4'(STEP1_RST)
  };

  state_e state;
  steps_t steps;
  steps_t pend;
  logic   pend_v;
  logic   acc;
  logic   wrap;
  logic   do_start;
  logic   do_stop;
  logic   do_clr;
  logic   do_load;
  logic   in_run;

  // A pending LOAD stalls every op until its wrap.
  assign cmd.cmd_ready = ~pend_v;
  assign acc    = cmd.cmd_valid & ~pend_v;
  assign in_run = (state == ST_RUN);

  assign do_start = acc & (cmd.cmd_op == OP_START);
  assign do_stop  = acc & (cmd.cmd_op == OP_STOP);
  assign do_clr   = acc & (cmd.cmd_op == OP_CLEAR);
  assign do_load  = acc & (cmd.cmd_op == OP_LOAD);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk1  (clk1),
    .rst_n (rst_n),
    .en    (in_run),
    .clr   (do_clr),
    .wrap  (wrap)
  );

  // FSM, channel counters, steps and LOAD buffer.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      out_1   <= '0;
      out_2   <= '0;
      tick    <= 1'b0;
      steps   <= STEPS_RST;
      pend    <= '0;
      pend_v  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (do_clr) begin
        out_1 <= '0;
        out_2 <= '0;
      end else if (wrap) begin
        out_1 <= out_1 + {4'h0, steps.step1};
        out_2 <= out_2 + {4'h0, steps.step2};
        tick  <= 1'b1;
      end

      if (wrap && pend_v) begin
        steps <= pend;
      end else if (do_load && !in_run) begin
        steps <= steps_t'(cmd.cmd_data);
      end

      if (do_load && in_run) begin
        pend   <= steps_t'(cmd.cmd_data);
        pend_v <= 1'b1;
      end else if (do_stop || wrap) begin
        pend_v <= 1'b0;
      end

      if (do_start) begin
        state   <= ST_RUN;
        running <= 1'b1;
      end else if (do_stop) begin
        state   <= ST_IDLE;
        running <= 1'b0;
      end
    end
  end

endmodule
